// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// applies decode/execute redirects and hazard stalls, and produces the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        whetherjump,
  input  logic [31:0] jumpaddress,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] instruction
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] PC_STEP    = AW'(4);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  // FETCH: request at pc; HOLD: word captured under stall, awaiting release;
  // DRAIN: an unaccepted request must stay on the bus until memory takes it.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] hold_instr, hold_instr_n;
  logic [AW-1:0] drain_addr, drain_addr_n;
  logic [AW-1:0] pc4_n, instruction_n;

  logic          redirect;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_plus4;

  // Redirect selection: execute-stage branch outranks decode-stage jump.
  always_comb begin
    redirect = branch_taken | whetherjump;
    target   = (branch_taken ? branch_target : jumpaddress) & ALIGN_MASK;
    pc_plus4 = pc + PC_STEP;
  end

  // Memory request depends only on registered state and reset.
  always_comb begin
    imem_req  = reset & (state != HOLD);
    imem_addr = (state == DRAIN) ? drain_addr : pc;
  end

  // Next-state and next-register computation.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    hold_instr_n  = hold_instr;
    drain_addr_n  = drain_addr;
    pc4_n         = pc4;
    instruction_n = instruction;

    case (state)
      FETCH: begin
        if (redirect) begin
          pc4_n         = '0;
          instruction_n = '0;
          pc_n          = target;
          if (!imem_ready) begin
            drain_addr_n = pc;
            state_n      = DRAIN;
          end
        end else if (imem_ready && !stall) begin
          pc4_n         = pc_plus4;
          instruction_n = imem_rdata;
          pc_n          = pc_plus4;
        end else if (imem_ready) begin
          hold_instr_n = imem_rdata;
          state_n      = HOLD;
        end else if (!stall) begin
          pc4_n         = '0;
          instruction_n = '0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc4_n         = '0;
          instruction_n = '0;
          pc_n          = target;
          state_n       = FETCH;
        end else if (!stall) begin
          pc4_n         = pc_plus4;
          instruction_n = hold_instr;
          pc_n          = pc_plus4;
          state_n       = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          pc4_n         = '0;
          instruction_n = '0;
          pc_n          = target;
        end else if (!stall) begin
          pc4_n         = '0;
          instruction_n = '0;
        end
        if (imem_ready) begin
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      hold_instr  <= '0;
      drain_addr  <= '0;
      pc4         <= '0;
      instruction <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      hold_instr  <= hold_instr_n;
      drain_addr  <= drain_addr_n;
      pc4         <= pc4_n;
      instruction <= instruction_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        whetherjump;
  logic [31:0] jumpaddress;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] instruction;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_pc4;
  logic [31:0] w_instr;

  int n_checks = 0;
  int n_errors = 0;

  // Memory returns a word derived from its address.
  assign imem_rdata = imem_addr ^ KEY;
  assign w_rdata    = w_addr ^ KEY;

  if_stage u_dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .whetherjump  (whetherjump),
    .jumpaddress  (jumpaddress),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc4          (pc4),
    .instruction  (instruction)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .whetherjump  (whetherjump),
    .jumpaddress  (jumpaddress),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (w_rdata),
    .pc4          (w_pc4),
    .instruction  (w_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program counter, addresses whose data must be discarded,
  // and words fetched under stall that are still owed to decode.
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic [31:0] drain_q[$];
  logic [31:0] held_q[$];

  task automatic bubble();
    m_pc4   = 32'h0;
    m_instr = 32'h0;
  endtask

  // One clock cycle: drive inputs, check request, advance model, check IF/ID.
  task automatic step(input logic r, input logic s, input logic wj, input logic [31:0] ja,
                      input logic bt, input logic [31:0] bta, input logic rdy);
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        redir;
    logic [31:0] tgt;
    reset = r; stall = s; whetherjump = wj; jumpaddress = ja;
    branch_taken = bt; branch_target = bta; imem_ready = rdy;
    #1;
    exp_addr = m_pc;
    if (!r) exp_req = 1'b0;
    else if (drain_q.size() > 0) begin exp_req = 1'b1; exp_addr = drain_q[0]; end
    else if (held_q.size() > 0) exp_req = 1'b0;
    else exp_req = 1'b1;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_addr);

    redir = bt | wj;
    tgt   = (bt ? bta : ja) & 32'hFFFF_FFFC;
    if (!r) begin
      m_pc = 32'h0; drain_q.delete(); held_q.delete(); bubble();
    end else if (drain_q.size() > 0) begin
      if (rdy) void'(drain_q.pop_front());
      if (redir) begin bubble(); m_pc = tgt; end
      else if (!s) bubble();
    end else if (held_q.size() > 0) begin
      if (redir) begin bubble(); m_pc = tgt; held_q.delete(); end
      else if (!s) begin
        m_instr = held_q.pop_front();
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc;
      end
    end else begin
      if (redir) begin
        bubble();
        if (!rdy) drain_q.push_back(m_pc);
        m_pc = tgt;
      end else if (rdy && s) held_q.push_back(m_pc ^ KEY);
      else if (rdy) begin
        m_instr = m_pc ^ KEY;
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc;
      end else if (!s) bubble();
    end

    @(posedge clk);
    #1;
    check("pc4", pc4, m_pc4);
    check("instruction", instruction, m_instr);
    @(negedge clk);
  endtask

  task automatic run(input logic wj, input logic [31:0] ja, input logic bt, input logic [31:0] bta,
                     input logic s, input logic rdy);
    step(1'b1, s, wj, ja, bt, bta, rdy);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; whetherjump = 1'b0; jumpaddress = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0; imem_ready = 1'b1;
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0;
    @(negedge clk);

    // Reset and stream
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_pc4", pc4, 32'h0);
    check("rst_instr", instruction, 32'h0);
    run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("first_instr", instruction, 32'hA5A5_0000);
    check("first_pc4", pc4, 32'h4);
    check("second_addr", imem_addr, 32'h4);
    run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Stall with accept at 0x8
    check("stall_addr", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      check("stall_pc4_frozen", pc4, 32'h8);
    end
    check("stall_req_low", 32'(imem_req), 32'h0);
    run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("unstall_instr", instruction, 32'hA5A5_0008);
    check("unstall_pc4", pc4, 32'hC);
    check("unstall_addr", imem_addr, 32'hC);
    run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Jump redirect at 0x10
    check("jump_from", imem_addr, 32'h10);
    run(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b1);
    check("jump_addr", imem_addr, 32'h400);
    check("jump_bubble", instruction, 32'h0);
    run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("jump_pc4", pc4, 32'h404);

    // Simultaneous redirects: branch wins
    run(1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 1'b1);
    check("both_addr", imem_addr, 32'h80);

    // Redirect during memory wait
    run(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    run(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0);
    check("drain_addr0", imem_addr, 32'h20);
    check("drain_bubble0", instruction, 32'h0);
    for (int i = 0; i < 2; i++) begin
      run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("drain_addr", imem_addr, 32'h20);
      check("drain_bubble", instruction, 32'h0);
    end
    run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("drain_next", imem_addr, 32'h100);
    check("drain_discard", instruction, 32'h0);

    // Reset mid-DRAIN, then wrap on the high-reset-PC instance
    run(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 1'b1);
    run(1'b1, 32'h50, 1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_drain", imem_addr, 32'h30);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("rst_drain_req", 32'(imem_req), 32'h0);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    run(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("restart_instr", instruction, 32'hA5A5_0000);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_instr", w_instr, 32'h5A5A_FFFC);
    check("wrap_next_addr", w_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, wj, bt, rdy;
      r   = ($urandom_range(0, 99) != 0);
      s   = ($urandom_range(0, 4) == 0);
      wj  = ($urandom_range(0, 15) == 0);
      bt  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      step(r, s, wj, $urandom, bt, $urandom, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, and the producer of the IF/ID pipeline register consumed by the decode stage. It owns the PC and issues requests to instruction memory over a req/ready handshake that tolerates wait states. It applies redirects from decode (j/jal/jr) and execute (taken branch), honours hazard-unit stalls, and inserts NOP bubbles (32'h0) on flush or memory wait.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled on rising edge of clk.
- stall  in  1  hazard unit: hold PC and IF/ID register.
- whetherjump  in  1  decode-stage redirect (j/jal/jr).
- jumpaddress  in  32  decode-stage redirect target.
- branch_taken  in  1  execute-stage taken-branch redirect.
- branch_target  in  32  execute-stage branch target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch byte address, bits [1:0] always 0.
- imem_ready  in  1  memory accepts request; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- pc4  out  32  IF/ID register: fetched address + 4.
- instruction  out  32  IF/ID register: fetched instruction.

## Operation
- Registers: pc, state {FETCH, HOLD, DRAIN}, hold_instr, drain_addr, pc4, instruction.
- Redirect = branch_taken | whetherjump. Target = branch_target when branch_taken, else jumpaddress; bits [1:0] are cleared. branch_taken wins when both are asserted.
- Bubble: pc4 <= 0, instruction <= 0.
- Redirect overrides stall in every state.
- pc + 4 is computed modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- FETCH: imem_req=1, imem_addr=pc.
  - Redirect & imem_ready: bubble, pc <= target, stay FETCH. The returned word is discarded.
  - Redirect & !imem_ready: bubble, drain_addr <= pc, pc <= target, go to DRAIN.
  - imem_ready & !stall: pc4 <= pc+4, instruction <= imem_rdata, pc <= pc+4.
  - imem_ready & stall: hold_instr <= imem_rdata, go to HOLD. IF/ID and pc are unchanged.
  - !imem_ready & !stall: bubble; pc unchanged.
  - !imem_ready & stall: no change.
- HOLD: imem_req=0, imem_addr=pc.
  - Redirect: bubble, pc <= target, go to FETCH. hold_instr is dropped.
  - !stall: pc4 <= pc+4, instruction <= hold_instr, pc <= pc+4, go to FETCH.
  - stall: no change.
- DRAIN: imem_req=1, imem_addr=drain_addr. An unaccepted request is never withdrawn or changed.
  - Redirect: bubble, pc <= target (newest target wins). Go to FETCH if imem_ready, else stay in DRAIN.
  - imem_ready: data is discarded, go to FETCH. IF/ID gets a bubble, or holds if stall.
  - !imem_ready: IF/ID gets a bubble, or holds if stall.
- Reset (reset=0 at an edge), from any state including mid-DRAIN:
  - pc=RESET_PC, state=FETCH, pc4=0, instruction=0, hold_instr=0, drain_addr=0.
  - While reset is low, imem_req is forced to 0.
  - An abandoned memory transaction is the memory's responsibility to drop on reset.

## Timing
- imem_req and imem_addr are functions of state, pc, drain_addr and reset only. They never depend combinationally on imem_ready or on the redirect inputs.
- First request: the first cycle with reset=1 has imem_req=1 and imem_addr=RESET_PC.
- With imem_ready tied to 1:
  - Instruction at address A appears on instruction and pc4 one cycle after imem_addr=A.
  - Throughput is one instruction per cycle.
- Redirect sampled at edge N: imem_addr = target in cycle N+1 (FETCH case), and IF/ID holds a bubble in cycle N+1.
- A stall lasting k cycles holds pc4 and instruction constant for exactly k cycles. Each fetched word is delivered exactly once, with no duplication or loss.
- Memory wait of w cycles (ready low, no stall): w bubbles enter IF/ID.

## Test plan
- Reset and stream:
  - Stimulus: reset low 2 cycles then high; ready=1; memory returns word = address ^ 32'hA5A5_0000.
  - Required: outputs 0 during reset. Cycle 1 after release: imem_addr=0. Cycle 2: instruction=32'hA5A5_0000, pc4=4. Addresses then increment by 4 each cycle.
- Jump redirect:
  - Stimulus: in the cycle imem_addr=32'h10, assert whetherjump, jumpaddress=32'h400.
  - Required: next cycle imem_addr=32'h400 and IF/ID=bubble. The following cycle pc4=32'h404.
- Simultaneous redirects:
  - Stimulus: assert branch_taken (target 32'h80) and whetherjump (target 32'h200) in the same cycle.
  - Required: imem_addr=32'h80 next cycle.
- Stall with accept:
  - Stimulus: at imem_addr=32'h8, ready=1 and stall=1 for 3 cycles.
  - Required: IF/ID frozen and imem_req=0 during the stall. After release, instruction = word@8 and pc4=32'hC, then 32'hC is fetched. No word is lost or duplicated.
- Redirect during wait:
  - Stimulus: ready=0 at imem_addr=32'h20; assert branch_taken with target 32'h100; hold ready=0 2 more cycles, then ready=1.
  - Required: imem_addr stays 32'h20 until accepted, and that data is discarded. The next request is 32'h100. IF/ID holds bubbles throughout.
- Reset mid-DRAIN and wrap:
  - Stimulus: assert reset while in DRAIN.
  - Required: imem_req=0 during reset, then restart at RESET_PC.
  - Stimulus: set RESET_PC=32'hFFFF_FFFC with ready=1.
  - Required: pc4=0 and the next imem_addr=0.
